// File: rtl/ds18b20_reader.sv
// ds18b20_reader: sequences a single DS18B20 temperature read over an
// external 1-Wire byte master.
//
// Sequence: bus reset, SKIP ROM (0xCC), CONVERT T (0x44), conversion wait,
// bus reset, SKIP ROM, READ SCRATCHPAD (0xBE), nine byte reads, CRC check.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start             : request one read (accepted only when idle)
//   busy              : sequence in progress, through the done cycle
//   done              : one-cycle pulse at the end of every sequence
//   temp_raw          : signed raw temperature {byte1, byte0}, 1/16 degC LSB
//   temp_valid        : one-cycle pulse with done when temp_raw was updated
//   presence_error    : no presence (or bus error) on a bus reset
//   crc_error         : scratchpad CRC mismatch, all-zero scratchpad or bus error
//   ow_op_start       : one-cycle command pulse to the byte master
//   ow_op_type        : 01 reset, 10 write byte, 11 read byte
//   ow_byte_to_write  : byte for write commands
//   ow_byte_read      : byte returned by the master
//   ow_op_done        : master completion pulse
//   ow_presence       : master presence result
//   ow_error          : master error flag
module ds18b20_reader #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned CONV_TIME_MS = 750
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] temp_raw,
    output logic        temp_valid,
    output logic        presence_error,
    output logic        crc_error,
    output logic        ow_op_start,
    output logic [1:0]  ow_op_type,
    output logic [7:0]  ow_byte_to_write,
    input  logic [7:0]  ow_byte_read,
    input  logic        ow_op_done,
    input  logic        ow_presence,
    input  logic        ow_error
);

    localparam int unsigned CONV_CYCLES = CLK_FREQ / 1000 * CONV_TIME_MS;

    localparam logic [1:0] OP_RESET = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StConvWait,
        StCrcCheck,
        StDone
    } state_t;

    // Which bus operation of the sequence is currently in flight.
    typedef enum logic [2:0] {
        StepRst1,
        StepSkip1,
        StepConvert,
        StepRst2,
        StepSkip2,
        StepReadSp,
        StepRead
    } step_t;

    state_t      state;
    step_t       step;
    step_t       next_step;
    logic [3:0]  byte_cnt;
    logic [7:0]  crc;
    logic [7:0]  scratch [9];
    logic [31:0] wait_cnt;
    logic        scratch_any;

    function automatic logic [1:0] op_type_of(input step_t s);
        case (s)
            StepRst1, StepRst2: return OP_RESET;
            StepRead:           return OP_READ;
            default:            return OP_WRITE;
        endcase
    endfunction

    function automatic logic [7:0] op_byte_of(input step_t s);
        case (s)
            StepSkip1, StepSkip2: return 8'hCC;
            StepConvert:          return 8'h44;
            StepReadSp:           return 8'hBE;
            default:              return 8'h00;
        endcase
    endfunction

    function automatic step_t next_step_of(input step_t s);
        case (s)
            StepRst1:    return StepSkip1;
            StepSkip1:   return StepConvert;
            StepConvert: return StepRst2;
            StepRst2:    return StepSkip2;
            StepSkip2:   return StepReadSp;
            default:     return StepRead;
        endcase
    endfunction

    // Dallas/Maxim CRC-8, reflected polynomial 0x8C, data LSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] data);
        logic [7:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
            else                c = c >> 1;
        end
        return c;
    endfunction

    always_comb begin
        next_step = next_step_of(step);
    end

    // An all-zero scratchpad passes the CRC, so it is rejected separately.
    always_comb begin
        scratch_any = 1'b0;
        for (int i = 0; i < 9; i++) begin
            scratch_any = scratch_any | (|scratch[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            step             <= StepRst1;
            byte_cnt         <= 4'd0;
            crc              <= 8'h00;
            wait_cnt         <= 32'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            temp_raw         <= 16'h0000;
            temp_valid       <= 1'b0;
            presence_error   <= 1'b0;
            crc_error        <= 1'b0;
            ow_op_start      <= 1'b0;
            ow_op_type       <= 2'b00;
            ow_byte_to_write <= 8'h00;
            for (int i = 0; i < 9; i++) begin
                scratch[i] <= 8'h00;
            end
        end else begin
            ow_op_start <= 1'b0;
            done        <= 1'b0;
            temp_valid  <= 1'b0;

            case (state)
                StIdle: begin
                    if (start) begin
                        busy             <= 1'b1;
                        presence_error   <= 1'b0;
                        crc_error        <= 1'b0;
                        byte_cnt         <= 4'd0;
                        crc              <= 8'h00;
                        step             <= StepRst1;
                        state            <= StIssue;
                        ow_op_start      <= 1'b1;
                        ow_op_type       <= OP_RESET;
                        ow_byte_to_write <= 8'h00;
                    end
                end

                StIssue: begin
                    state <= StWait;
                end

                StWait: begin
                    if (ow_op_done) state <= StCapture;
                end

                // Master results are registered on op_done, so sample them here.
                StCapture: begin
                    if (step == StepRst1 || step == StepRst2) begin
                        if (!ow_presence || ow_error) begin
                            presence_error <= 1'b1;
                            state          <= StDone;
                            done           <= 1'b1;
                        end else begin
                            step             <= next_step;
                            state            <= StIssue;
                            ow_op_start      <= 1'b1;
                            ow_op_type       <= op_type_of(next_step);
                            ow_byte_to_write <= op_byte_of(next_step);
                        end
                    end else if (ow_error) begin
                        crc_error <= 1'b1;
                        state     <= StDone;
                        done      <= 1'b1;
                    end else if (step == StepConvert) begin
                        wait_cnt <= 32'd0;
                        state    <= StConvWait;
                    end else if (step == StepRead) begin
                        scratch[byte_cnt] <= ow_byte_read;
                        crc               <= crc8_byte(crc, ow_byte_read);
                        if (byte_cnt == 4'd8) begin
                            state <= StCrcCheck;
                        end else begin
                            byte_cnt         <= byte_cnt + 4'd1;
                            state            <= StIssue;
                            ow_op_start      <= 1'b1;
                            ow_op_type       <= OP_READ;
                            ow_byte_to_write <= 8'h00;
                        end
                    end else begin
                        step             <= next_step;
                        state            <= StIssue;
                        ow_op_start      <= 1'b1;
                        ow_op_type       <= op_type_of(next_step);
                        ow_byte_to_write <= op_byte_of(next_step);
                    end
                end

                // Occupies exactly CONV_CYCLES cycles between CAPTURE and ISSUE.
                StConvWait: begin
                    if (wait_cnt == CONV_CYCLES - 1) begin
                        step             <= next_step;
                        state            <= StIssue;
                        ow_op_start      <= 1'b1;
                        ow_op_type       <= op_type_of(next_step);
                        ow_byte_to_write <= op_byte_of(next_step);
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                StCrcCheck: begin
                    if (crc == 8'h00 && scratch_any) begin
                        temp_raw   <= {scratch[1], scratch[0]};
                        temp_valid <= 1'b1;
                    end else begin
                        crc_error <= 1'b1;
                    end
                    state <= StDone;
                    done  <= 1'b1;
                end

                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ds18b20_reader.sv
// Self-checking bench for ds18b20_reader: a behavioural 1-Wire byte master /
// DS18B20 responder plus a scoreboard of expected sequences and results.
module tb_ds18b20_reader;

    localparam int unsigned CLK_FREQ     = 100_000;
    localparam int unsigned CONV_TIME_MS = 1;
    localparam int          CONV_CYCLES  = 100;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] temp_raw;
    logic        temp_valid;
    logic        presence_error;
    logic        crc_error;
    logic        ow_op_start;
    logic [1:0]  ow_op_type;
    logic [7:0]  ow_byte_to_write;
    logic [7:0]  ow_byte_read;
    logic        ow_op_done;
    logic        ow_presence;
    logic        ow_error;

    ds18b20_reader #(
        .CLK_FREQ     (CLK_FREQ),
        .CONV_TIME_MS (CONV_TIME_MS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .temp_raw         (temp_raw),
        .temp_valid       (temp_valid),
        .presence_error   (presence_error),
        .crc_error        (crc_error),
        .ow_op_start      (ow_op_start),
        .ow_op_type       (ow_op_type),
        .ow_byte_to_write (ow_byte_to_write),
        .ow_byte_read     (ow_byte_read),
        .ow_op_done       (ow_op_done),
        .ow_presence      (ow_presence),
        .ow_error         (ow_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC over the first n bytes of msg (byte i at msg[8*i +: 8]).
    function automatic logic [7:0] ref_crc(input logic [71:0] msg, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 8 * n; i++) begin
            fb = c[0] ^ msg[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    // Responder state and event log.
    logic [7:0] resp_bytes [9];
    bit         pres1;
    int         rd_idx;
    int         rst_idx;
    bit         pending;
    int         lat;
    logic [1:0] cur_type;
    logic [7:0] cur_byte;
    logic [9:0] oplog [$];
    int         cyc;
    int         conv_done_cyc;
    int         rst2_cyc;
    int         last_done_cyc;
    int         proto_bad;
    int         done_cnt;
    int         tv_cnt;
    logic [15:0] exp_temp;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Byte master: answers each command after 1..4 cycles with a done pulse,
    // its results held stable until the next command.
    initial begin
        ow_op_done    = 1'b0;
        ow_byte_read  = 8'h00;
        ow_presence   = 1'b0;
        ow_error      = 1'b0;
        pending       = 1'b0;
        last_done_cyc = -10;
        forever begin
            @(posedge clk);
            #1;
            ow_op_done = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                if (ow_op_start || ow_op_type !== cur_type || ow_byte_to_write !== cur_byte)
                    proto_bad++;
                lat--;
                if (lat == 0) begin
                    pending       = 1'b0;
                    ow_op_done    = 1'b1;
                    ow_error      = 1'b0;
                    last_done_cyc = cyc;
                    if (cur_type == 2'b01) begin
                        ow_presence = (rst_idx == 0) ? pres1 : 1'b1;
                        rst_idx++;
                    end else if (cur_type == 2'b11) begin
                        ow_byte_read = (rd_idx < 9) ? resp_bytes[rd_idx] : 8'h00;
                        rd_idx++;
                    end else if (cur_byte == 8'h44) begin
                        conv_done_cyc = cyc;
                    end
                end
            end else if (ow_op_start) begin
                if (cyc == last_done_cyc + 1) proto_bad++;
                cur_type = ow_op_type;
                cur_byte = ow_byte_to_write;
                oplog.push_back({cur_type, (cur_type == 2'b10) ? cur_byte : 8'h00});
                if (cur_type == 2'b01 && rst_idx == 1) rst2_cyc = cyc;
                pending = 1'b1;
                lat     = $urandom_range(1, 4);
            end
        end
    end

    initial begin
        done_cnt = 0;
        tv_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (temp_valid) tv_cnt++;
        end
    end

    function automatic logic [31:0] all_outputs();
        return {busy, done, temp_valid, temp_raw, presence_error, crc_error,
                ow_op_start, ow_op_type, ow_byte_to_write};
    endfunction

    task automatic prepare(input logic [71:0] bytes, input bit pres);
        for (int i = 0; i < 9; i++) resp_bytes[i] = bytes[8*i +: 8];
        pres1         = pres;
        rd_idx        = 0;
        rst_idx       = 0;
        oplog.delete();
        done_cnt      = 0;
        tv_cnt        = 0;
        proto_bad     = 0;
        conv_done_cyc = -1;
        rst2_cyc      = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic run_read(input logic [71:0] bytes, input bit pres, input string name);
        bit         ok_crc;
        bit         success;
        bit         seen;
        logic       g_busy;
        logic       g_tv;
        logic       g_perr;
        logic       g_cerr;
        logic [15:0] g_temp;
        logic [9:0] exp_ops [$];

        ok_crc  = (ref_crc(bytes, 9) == 8'h00) && (bytes != 72'h0);
        success = pres && ok_crc;
        exp_ops.push_back(10'h100);
        if (pres) begin
            exp_ops.push_back(10'h2CC);
            exp_ops.push_back(10'h244);
            exp_ops.push_back(10'h100);
            exp_ops.push_back(10'h2CC);
            exp_ops.push_back(10'h2BE);
            for (int i = 0; i < 9; i++) exp_ops.push_back(10'h300);
        end

        prepare(bytes, pres);
        pulse_start();
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(posedge clk);
            #2;
            // A start while busy must be ignored.
            start = (n == 30 && pres) ? 1'b1 : 1'b0;
            if (done) begin
                seen   = 1'b1;
                g_busy = busy;
                g_tv   = temp_valid;
                g_temp = temp_raw;
                g_perr = presence_error;
                g_cerr = crc_error;
            end
        end
        start = 1'b0;
        check_eq({name, ":done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({name, ":busy_at_done"}, 32'(g_busy), 32'd1);
            check_eq({name, ":temp_valid"}, 32'(g_tv), 32'(success));
            if (success) exp_temp = {bytes[15:8], bytes[7:0]};
            check_eq({name, ":temp_raw"}, 32'(g_temp), 32'(exp_temp));
            check_eq({name, ":presence_error"}, 32'(g_perr), 32'(!pres));
            check_eq({name, ":crc_error"}, 32'(g_cerr), 32'(pres && !ok_crc));
            @(posedge clk);
            #2;
            check_eq({name, ":idle_after"}, {30'd0, busy, done}, 32'd0);
        end
        repeat (10) @(posedge clk);
        #2;
        check_eq({name, ":done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({name, ":tv_pulses"}, 32'(tv_cnt), 32'(success));
        check_eq({name, ":op_count"}, 32'(oplog.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < oplog.size(); i++)
            check_eq($sformatf("%s:op%0d", name, i), 32'(oplog[i]), 32'(exp_ops[i]));
        check_eq({name, ":protocol"}, 32'(proto_bad), 32'd0);
        if (pres)
            check_eq({name, ":conv_gap"}, 32'(rst2_cyc - conv_done_cyc - 2), 32'(CONV_CYCLES));
    endtask

    localparam logic [71:0] EXAMPLE = 72'h1C_10_0C_FF_7F_46_4B_05_50;

    initial begin
        logic [71:0] msg;
        logic [71:0] flip;
        int          mode;
        int          nops;
        bit          reached;

        exp_temp = 16'h0000;
        proto_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_outputs", all_outputs(), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("idle_after_reset", all_outputs(), 32'd0);

        run_read(EXAMPLE, 1'b1, "example");
        check_eq("example_value", 32'(temp_raw), 32'h0550);

        msg = EXAMPLE;
        msg[71:64] = 8'h1D;
        run_read(msg, 1'b1, "bad_crc");

        run_read(EXAMPLE, 1'b0, "no_presence");

        run_read(72'h0, 1'b1, "all_zero");

        // Reset while byte 4 of the scratchpad is being read.
        prepare(EXAMPLE, 1'b1);
        pulse_start();
        reached = 1'b0;
        for (int n = 0; n < 2000 && !reached; n++) begin
            @(posedge clk);
            #2;
            if (oplog.size() >= 11) reached = 1'b1;
        end
        check_eq("rst_mid:reached_byte4", 32'(reached), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mid:outputs", all_outputs(), 32'd0);
        exp_temp = 16'h0000;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        nops = oplog.size();
        repeat (50) @(posedge clk);
        #2;
        check_eq("rst_mid:no_ops", 32'(oplog.size()), 32'(nops));
        check_eq("rst_mid:idle", {30'd0, busy, done}, 32'd0);
        run_read(EXAMPLE, 1'b1, "after_rst");

        for (int t = 0; t < 6; t++) begin
            mode = $urandom_range(0, 2);
            msg  = {8'h00, $urandom(), $urandom()};
            msg[71:64] = ref_crc(msg, 8);
            if (mode == 1) begin
                flip = 72'h0;
                flip[$urandom_range(0, 71)] = 1'b1;
                msg = msg ^ flip;
            end
            run_read(msg, (mode != 2), $sformatf("rand%0d_m%0d", t, mode));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ds18b20_reader.md
DS18B20_READER -- requirements
Module: ds18b20_reader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter CONV_TIME_MS, default 750, conversion wait in ms; CONV_CYCLES = CLK_FREQ/1000*CONV_TIME_MS.
REQ-003 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  asynchronous, active-high reset
  start  in  1  request one temperature read
  busy  out  1  sequence in progress
  done  out  1  one-cycle pulse at end of every sequence (success or failure)
  temp_raw  out  16  signed raw temperature {byte1,byte0}, 1/16 degC LSB
  temp_valid  out  1  one-cycle pulse, temp_raw updated
  presence_error  out  1  no presence pulse on a bus reset
  crc_error  out  1  scratchpad CRC mismatch or bus error
  ow_op_start  out  1  one-cycle command pulse to the 1-Wire byte master
  ow_op_type  out  2  01 reset, 10 write byte, 11 read byte
  ow_byte_to_write  out  8  byte for write commands
  ow_byte_read  in  8  byte returned by the master
  ow_op_done  in  1  master completion pulse
  ow_presence  in  1  master presence result
  ow_error  in  1  master error flag
REQ-004 SHALL use reset rst, asynchronous, active-high, and clock clk.

Function
REQ-005 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-006 SHALL run: RESET -> write 0xCC -> write 0x44 -> CONV_WAIT -> RESET -> write 0xCC -> write 0xBE -> read 9 bytes -> CRC_CHECK -> DONE.
REQ-007 SHALL implement each master op as ISSUE (ow_op_start=1, ow_op_type and ow_byte_to_write valid, one cycle) -> WAIT (until ow_op_done) -> CAPTURE (one cycle).
REQ-008 SHALL sample ow_byte_read, ow_presence and ow_error only in CAPTURE, the cycle after ow_op_done, because the master registers them on op_done.
REQ-009 SHALL hold ow_op_type and ow_byte_to_write stable from ISSUE until ow_op_done.
REQ-010 SHALL emit the next ow_op_start no earlier than the cycle after CAPTURE, so the master has returned to idle.
REQ-011 SHALL, if ow_presence=0 or ow_error=1 after either RESET, set presence_error=1 and go directly to DONE with no further bus ops.
REQ-012 SHALL, in CONV_WAIT, count exactly CONV_CYCLES clk cycles after the 0x44 CAPTURE before issuing the second RESET.
REQ-013 SHALL store read bytes 0..8 in a 9x8 buffer indexed by a 4-bit counter that runs 0 to 8 and does not wrap.
REQ-014 SHALL update a CRC-8 (poly x^8+x^5+x^4+1, reflected 0x8C, init 0x00, LSB first) with each captured byte, all 9 bytes included.
REQ-015 SHALL, in CRC_CHECK, require CRC==0x00 and scratchpad not all 0x00; otherwise crc_error=1, temp_raw unchanged.
REQ-016 SHALL, on success, load temp_raw={buf[1],buf[0]} and pulse temp_valid together with done.
REQ-017 SHALL clear presence_error and crc_error on an accepted start; errors otherwise persist.
REQ-018 SHALL assert busy from the cycle after an accepted start through the DONE cycle inclusive.
REQ-019 SHALL treat ow_op_done outside WAIT states as don't-care.

Reset
REQ-020 SHALL, on rst, go to IDLE immediately, even mid-sequence, and clear busy, done, temp_valid, errors, ow_op_start, ow_op_type, ow_byte_to_write, temp_raw (0x0000), buffer, byte counter, CRC and wait counter.
REQ-021 SHALL, after rst releases mid-sequence, issue no bus op until a new start.

Verification
REQ-022 SHALL cover: start, slave model returns 50 05 4B 46 7F FF 0C 10 1C -> temp_raw=0x0550, temp_valid and done pulse together, errors 0.
REQ-023 SHALL cover: first reset returns ow_presence=0 -> presence_error=1, done pulse, only 1 ow_op_start issued.
REQ-024 SHALL cover: byte 8 corrupted to 0x1D -> crc_error=1, temp_raw keeps previous value, no temp_valid.
REQ-025 SHALL cover: CONV_TIME_MS set so CONV_CYCLES=100 -> exactly 100 cycles between 0x44 CAPTURE and the second reset ow_op_start; start during busy ignored.
REQ-026 SHALL cover: rst asserted during byte-4 read -> all outputs 0 same cycle, no ow_op_start until next start, next read succeeds.
REQ-027 SHALL cover: all nine bytes 0x00 -> crc_error=1.
